// File: rtl/frame_capture_arbiter_if.sv
// frame_capture_arbiter_if
//   Bundles the sample streams, per-channel requests and RAM write port of
//   the frame-capture arbiter.
//   master : sample/request source (drives data_in, stb_in, req; observes the rest)
//   slave  : the arbiter itself
//   data_in   N*WIDTH  channel k sample on [k*WIDTH +: WIDTH]
//   stb_in    N        per-channel sample strobe
//   req       N        per-channel capture request (level)
//   grant     N        one-hot grant
//   done      N        frame-complete pulse on granted channel's bit
//   abort     1        request dropped before frame completion
//   active_ch CH_BITS  current / last granted channel
//   ram_addr/ram_data/ram_wren  RAM write port
//   busy      1        arbiter not idle
interface frame_capture_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int LENGTH  = 11,
  parameter int N       = 4,
  parameter int CH_BITS = 2
);
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       stb_in;
  logic [N-1:0]       req;
  logic [N-1:0]       grant;
  logic [N-1:0]       done;
  logic               abort;
  logic [CH_BITS-1:0] active_ch;
  logic [LENGTH-1:0]  ram_addr;
  logic [WIDTH-1:0]   ram_data;
  logic               ram_wren;
  logic               busy;

  modport master (
    output data_in, stb_in, req,
    input  grant, done, abort, active_ch, ram_addr, ram_data, ram_wren, busy
  );

  modport slave (
    input  data_in, stb_in, req,
    output grant, done, abort, active_ch, ram_addr, ram_data, ram_wren, busy
  );
endinterface

// File: rtl/frame_capture_arbiter.sv
// frame_capture_arbiter
//   Shares one 2^LENGTH x WIDTH frame-capture RAM between N sample streams.
//   One requesting channel is granted at a time; its strobed samples are
//   written to consecutive addresses until the frame is full, then done is
//   pulsed and the grant is held until the request is released. Dropping the
//   request mid-frame abandons the frame with an abort pulse.
// Ports
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    frame_capture_arbiter_if.slave (samples, requests, grant/status,
//          RAM write port); all outputs are registered
// Configuration
//   FRAME_CAPTURE_ARB_FIXED_PRIO_EN defined : lowest requesting index wins
//   undefined (default)                     : round-robin from last+1
module frame_capture_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LENGTH  = 11,
  parameter int N       = 4,
  parameter int CH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  frame_capture_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_RELEASE} state_t;

  state_t             state_q;
  logic [N-1:0]       grant_q;
  logic [N-1:0]       done_q;
  logic               abort_q;
  logic [CH_BITS-1:0] active_ch_q;
  logic [CH_BITS-1:0] last_q;
  logic [LENGTH-1:0]  cnt_q;
  logic [LENGTH-1:0]  ram_addr_q;
  logic [WIDTH-1:0]   ram_data_q;
  logic               ram_wren_q;
  logic               busy_q;

  logic [CH_BITS-1:0] win_d;
  int                 idx;

  function automatic logic [N-1:0] onehot(input logic [CH_BITS-1:0] c);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (c == CH_BITS'(k)) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic sel_bit(input logic [N-1:0] v, input logic [CH_BITS-1:0] c);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N; k++)
      if (c == CH_BITS'(k)) r = v[k];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sel_data(input logic [N*WIDTH-1:0] d,
                                                input logic [CH_BITS-1:0] c);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (c == CH_BITS'(k)) r = d[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // Winner selection. Loops run from the least to the most preferred
  // candidate so the last hit is the winner.
  always_comb begin
    win_d = '0;
    idx   = 0;
`ifdef FRAME_CAPTURE_ARB_FIXED_PRIO_EN
    for (int k = N - 1; k >= 0; k--)
      if (bus.req[k]) win_d = CH_BITS'(k);
`else
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_q) + i) % N;
      if (bus.req[idx]) win_d = CH_BITS'(idx);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      abort_q     <= 1'b0;
      active_ch_q <= '0;
      last_q      <= CH_BITS'(N - 1);
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q     <= '0;
      abort_q    <= 1'b0;
      ram_wren_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          grant_q <= '0;
          cnt_q   <= '0;
          if (|bus.req) begin
            grant_q     <= onehot(win_d);
            active_ch_q <= win_d;
            busy_q      <= 1'b1;
            state_q     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // A dropped request wins over any strobe in the same cycle,
          // including the one that would have completed the frame.
          if (!sel_bit(bus.req, active_ch_q)) begin
            abort_q <= 1'b1;
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= active_ch_q;
            state_q <= S_IDLE;
          end else if (sel_bit(bus.stb_in, active_ch_q)) begin
            ram_wren_q <= 1'b1;
            ram_addr_q <= cnt_q;
            ram_data_q <= sel_data(bus.data_in, active_ch_q);
            cnt_q      <= cnt_q + LENGTH'(1);
            if (cnt_q == {LENGTH{1'b1}}) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= onehot(active_ch_q);
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!sel_bit(bus.req, active_ch_q)) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= active_ch_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;
  assign bus.active_ch = active_ch_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_wren  = ram_wren_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_frame_capture_arbiter.sv
module tb_frame_capture_arbiter;
  localparam int WIDTH   = 16;
  localparam int LENGTH  = 11;
  localparam int N       = 4;
  localparam int CH_BITS = 2;
  localparam int DEPTH   = 1 << LENGTH;

  logic clk;
  logic rst_n;

  frame_capture_arbiter_if #(.WIDTH(WIDTH), .LENGTH(LENGTH), .N(N), .CH_BITS(CH_BITS)) bus ();

  frame_capture_arbiter #(.WIDTH(WIDTH), .LENGTH(LENGTH), .N(N), .CH_BITS(CH_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [N-1:0] done_last = '0;

  // Expected RAM writes: {addr, data}
  logic [LENGTH+WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented RAM write is popped from the scoreboard.
  always @(negedge clk) begin
    logic [LENGTH+WIDTH-1:0] e;
    if (bus.ram_wren === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected at %0t",
                 bus.ram_addr, bus.ram_data, $time);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ram_addr, bus.ram_data} !== e) begin
          errors++;
          $display("FAIL ram_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   bus.ram_addr, bus.ram_data, e[LENGTH+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
    if (bus.done !== '0) begin
      done_cnt++;
      done_last = bus.done;
    end
    if (bus.abort === 1'b1) abort_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    bus.data_in[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic push(input int a, input logic [WIDTH-1:0] d);
    logic [LENGTH-1:0] aa;
    aa = LENGTH'(a);
    exp_q.push_back({aa, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},     32'(bus.grant), 0);
    check({tag, "_done"},      32'(bus.done), 0);
    check({tag, "_abort"},     32'(bus.abort), 0);
    check({tag, "_active_ch"}, 32'(bus.active_ch), 0);
    check({tag, "_ram_addr"},  32'(bus.ram_addr), 0);
    check({tag, "_ram_data"},  32'(bus.ram_data), 0);
    check({tag, "_ram_wren"},  32'(bus.ram_wren), 0);
    check({tag, "_busy"},      32'(bus.busy), 0);
  endtask

  initial begin
    int n;
    int i;
    logic s2;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.stb_in  = '0;
    bus.data_in = '0;
    step();
    step();
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Channel 0 full frame, data = address
    bus.req = 4'b0101;
    step();
    check("grant_ch0", 32'(bus.grant), 32'b0001);
    check("busy_ch0", 32'(bus.busy), 1);
    check("active_ch0", 32'(bus.active_ch), 0);
    for (int a = 0; a < DEPTH; a++) begin
      bus.stb_in = 4'b0001;
      set_data(0, WIDTH'(a));
      push(a, WIDTH'(a));
      step();
    end
    bus.stb_in = '0;
    step();
    check("done_pulse_ch0", 32'(bus.done), 32'b0001);
    step();
    check("done_one_cycle", 32'(bus.done), 0);
    step();
    step();
    check("done_count_frame0", 32'(done_cnt), 1);
    check("done_bit_frame0", 32'(done_last), 32'b0001);
    check("abort_count_frame0", 32'(abort_cnt), 0);
    check("grant_hold_release", 32'(bus.grant), 32'b0001);
    check("no_pending_writes_frame0", 32'(exp_q.size()), 0);

    // Release ch0; ch2 still requesting wins round-robin
    bus.req = 4'b0100;
    step();
    check("grant_after_release", 32'(bus.grant), 0);
    check("busy_after_release", 32'(bus.busy), 0);
    step();
    check("grant_rr_ch2", 32'(bus.grant), 32'b0100);
    check("active_rr_ch2", 32'(bus.active_ch), 2);

    // Ch1 strobes alongside granted ch2; only ch2 data is written
    n = 0;
    i = 0;
    while (n < 100) begin
      s2 = (i % 3) != 0;
      bus.stb_in = {1'b0, s2, 1'b1, 1'b0};
      set_data(1, 16'hAAAA ^ WIDTH'(i));
      set_data(2, 16'h1000 + WIDTH'(n));
      if (s2) begin
        push(n, 16'h1000 + WIDTH'(n));
        n++;
      end
      step();
      i++;
    end
    // Drop request after 100 writes, with a strobe that must not be written
    bus.req    = 4'b0000;
    bus.stb_in = 4'b0100;
    set_data(2, 16'hDEAD);
    step();
    bus.stb_in = '0;
    check("abort_pulse", 32'(bus.abort), 1);
    check("busy_after_abort", 32'(bus.busy), 0);
    check("grant_after_abort", 32'(bus.grant), 0);
    check("wren_on_abort", 32'(bus.ram_wren), 0);
    step();
    check("abort_one_cycle", 32'(bus.abort), 0);

    // Same channel again: restarts at address 0; abort on the final strobe
    bus.req = 4'b0100;
    step();
    check("grant_ch2_again", 32'(bus.grant), 32'b0100);
    for (int a = 0; a < DEPTH - 1; a++) begin
      bus.stb_in = 4'b0100;
      set_data(2, 16'h5000 + WIDTH'(a));
      push(a, 16'h5000 + WIDTH'(a));
      step();
    end
    bus.stb_in = 4'b0100;
    set_data(2, 16'hBEEF);
    bus.req = 4'b0000;
    step();
    bus.stb_in = '0;
    check("final_abort_pulse", 32'(bus.abort), 1);
    check("final_abort_no_wren", 32'(bus.ram_wren), 0);
    check("final_abort_no_done", 32'(bus.done), 0);
    step();
    step();
    check("done_count_after_final_abort", 32'(done_cnt), 1);
    check("abort_count_after_final_abort", 32'(abort_cnt), 2);

    // Ch1 short capture then abort, so last = 1
    bus.req = 4'b0010;
    step();
    check("grant_ch1", 32'(bus.grant), 32'b0010);
    for (int a = 0; a < 5; a++) begin
      bus.stb_in = 4'b0010;
      set_data(1, 16'h7700 + WIDTH'(a));
      push(a, 16'h7700 + WIDTH'(a));
      step();
    end
    bus.stb_in = '0;
    bus.req = 4'b0000;
    step();
    step();
    // From last = 1 the round-robin search prefers ch2 over ch0
    bus.req = 4'b0101;
    step();
    check("grant_rr_from_last1", 32'(bus.grant), 32'b0100);
    for (int a = 0; a < 10; a++) begin
      bus.stb_in = 4'b0100;
      set_data(2, 16'h3300 + WIDTH'(a));
      push(a, 16'h3300 + WIDTH'(a));
      step();
    end
    // Reset mid-capture while still strobing
    set_data(2, 16'hCAFE);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.stb_in = '0;
    check_reset_outputs("midreset");
    step();
    check("grant_after_reset_lowest", 32'(bus.grant), 32'b0001);
    check("active_after_reset", 32'(bus.active_ch), 0);
    check("done_count_after_reset", 32'(done_cnt), 1);
    check("abort_count_after_reset", 32'(abort_cnt), 3);

    bus.req = '0;
    step();
    step();
    check("grant_final_idle", 32'(bus.grant), 0);
    check("busy_final_idle", 32'(bus.busy), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
